// File: rtl/laser310_kbd_pkg.sv
// Shared definitions for the LASER310/VZ300 keyboard matrix responder:
// decoder states, scan-code constants, synthesized-key indices and the
// matrix positions those synthesized keys drive.
package laser310_kbd_pkg;

    // Decoder state: which prefix bytes have been seen for the current key.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kbd_state_t;

    // What the decoder asks the matrix registers to do with the current byte.
    typedef enum logic [1:0] {
        ACT_NONE    = 2'd0,
        ACT_PRESS   = 2'd1,
        ACT_RELEASE = 2'd2,
        ACT_CLEAR   = 2'd3
    } kbd_act_t;

    // A matrix position as reported by the scan-code map.
    typedef struct packed {
        logic       hit;
        logic [2:0] row;
        logic [2:0] col;
    } key_pos_t;

    // Protocol bytes.
    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_AA = 8'hAA;
    localparam logic [7:0] SC_FC = 8'hFC;
    localparam logic [7:0] SC_00 = 8'h00;
    localparam logic [7:0] SC_FF = 8'hFF;

    // Synthesized keys: each one stands for CTRL plus one target key.
    localparam int         EX_W    = 6;
    localparam logic [2:0] EX_LEFT  = 3'd0;
    localparam logic [2:0] EX_RIGHT = 3'd1;
    localparam logic [2:0] EX_UP    = 3'd2;
    localparam logic [2:0] EX_DOWN  = 3'd3;
    localparam logic [2:0] EX_ESC   = 3'd4;
    localparam logic [2:0] EX_BKSP  = 3'd5;

    // Matrix positions of CTRL and of the synthesized-key targets.
    localparam logic [2:0] CTRL_ROW   = 3'd1;
    localparam logic [2:0] CTRL_COL   = 3'd2;
    localparam logic [2:0] M_ROW      = 3'd4;
    localparam logic [2:0] M_COL      = 3'd5;
    localparam logic [2:0] COMMA_ROW  = 3'd4;
    localparam logic [2:0] COMMA_COL  = 3'd3;
    localparam logic [2:0] PERIOD_ROW = 3'd4;
    localparam logic [2:0] PERIOD_COL = 3'd1;
    localparam logic [2:0] SPACE_ROW  = 3'd4;
    localparam logic [2:0] SPACE_COL  = 3'd4;
    localparam logic [2:0] MINUS_ROW  = 3'd5;
    localparam logic [2:0] MINUS_COL  = 3'd2;

    // Build a hit entry for the map tables.
    function automatic key_pos_t kp(input logic [2:0] row, input logic [2:0] col);
        key_pos_t p;
        p.hit = 1'b1;
        p.row = row;
        p.col = col;
        return p;
    endfunction

    // Bytes that mean "keyboard reset/self-test/error": drop every key.
    function automatic logic is_reset_code(input logic [7:0] code);
        return (code == SC_AA) || (code == SC_FC) ||
               (code == SC_00) || (code == SC_FF);
    endfunction

    // Target key of a synthesized key (CTRL is added separately).
    function automatic key_pos_t ex_target(input logic [2:0] ex_idx);
        key_pos_t p;
        case (ex_idx)
            EX_LEFT:  p = kp(M_ROW, M_COL);
            EX_RIGHT: p = kp(COMMA_ROW, COMMA_COL);
            EX_UP:    p = kp(PERIOD_ROW, PERIOD_COL);
            EX_DOWN:  p = kp(SPACE_ROW, SPACE_COL);
            EX_ESC:   p = kp(MINUS_ROW, MINUS_COL);
            EX_BKSP:  p = kp(M_ROW, M_COL);
            default:  p = kp(CTRL_ROW, CTRL_COL);
        endcase
        return p;
    endfunction

endpackage

// File: rtl/laser310_kbd_map.sv
// Combinational PS/2 set-2 scan-code lookup. Physical keys come back as a
// matrix position; keys that the machine lacks but that we emulate as
// CTRL+key come back as a synthesized-key index instead.
module laser310_kbd_map
    import laser310_kbd_pkg::*;
(
    input  logic [7:0] i_code,
    input  logic       i_ext,
    output key_pos_t   o_key,
    output logic       o_ex_hit,
    output logic [2:0] o_ex_idx
);

    // Two tables selected by whether an E0 prefix preceded this byte.
    always_comb begin
        o_key    = '0;
        o_ex_hit = 1'b0;
        o_ex_idx = 3'd0;
        if (!i_ext) begin
            case (i_code)
                // row 0: R Q E - W T
                8'h2D: o_key = kp(3'd0, 3'd5);
                8'h15: o_key = kp(3'd0, 3'd4);
                8'h24: o_key = kp(3'd0, 3'd3);
                8'h1D: o_key = kp(3'd0, 3'd1);
                8'h2C: o_key = kp(3'd0, 3'd0);
                // row 1: F A D CTRL S G
                8'h2B: o_key = kp(3'd1, 3'd5);
                8'h1C: o_key = kp(3'd1, 3'd4);
                8'h23: o_key = kp(3'd1, 3'd3);
                8'h14: o_key = kp(CTRL_ROW, CTRL_COL);
                8'h1B: o_key = kp(3'd1, 3'd1);
                8'h34: o_key = kp(3'd1, 3'd0);
                // row 2: V Z C SHIFT X B (both shift keys)
                8'h2A: o_key = kp(3'd2, 3'd5);
                8'h1A: o_key = kp(3'd2, 3'd4);
                8'h21: o_key = kp(3'd2, 3'd3);
                8'h12: o_key = kp(3'd2, 3'd2);
                8'h59: o_key = kp(3'd2, 3'd2);
                8'h22: o_key = kp(3'd2, 3'd1);
                8'h32: o_key = kp(3'd2, 3'd0);
                // row 3: 4 1 3 - 2 5
                8'h25: o_key = kp(3'd3, 3'd5);
                8'h16: o_key = kp(3'd3, 3'd4);
                8'h26: o_key = kp(3'd3, 3'd3);
                8'h1E: o_key = kp(3'd3, 3'd1);
                8'h2E: o_key = kp(3'd3, 3'd0);
                // row 4: M SPACE , - . N
                8'h3A: o_key = kp(M_ROW, M_COL);
                8'h29: o_key = kp(SPACE_ROW, SPACE_COL);
                8'h41: o_key = kp(COMMA_ROW, COMMA_COL);
                8'h49: o_key = kp(PERIOD_ROW, PERIOD_COL);
                8'h31: o_key = kp(3'd4, 3'd0);
                // row 5: 7 0 8 '-' 9 6
                8'h3D: o_key = kp(3'd5, 3'd5);
                8'h45: o_key = kp(3'd5, 3'd4);
                8'h3E: o_key = kp(3'd5, 3'd3);
                8'h4E: o_key = kp(MINUS_ROW, MINUS_COL);
                8'h46: o_key = kp(3'd5, 3'd1);
                8'h36: o_key = kp(3'd5, 3'd0);
                // row 6: U P I ENTER O Y
                8'h3C: o_key = kp(3'd6, 3'd5);
                8'h4D: o_key = kp(3'd6, 3'd4);
                8'h43: o_key = kp(3'd6, 3'd3);
                8'h5A: o_key = kp(3'd6, 3'd2);
                8'h44: o_key = kp(3'd6, 3'd1);
                8'h35: o_key = kp(3'd6, 3'd0);
                // row 7: J ; K : L H
                8'h3B: o_key = kp(3'd7, 3'd5);
                8'h4C: o_key = kp(3'd7, 3'd4);
                8'h42: o_key = kp(3'd7, 3'd3);
                8'h52: o_key = kp(3'd7, 3'd2);
                8'h4B: o_key = kp(3'd7, 3'd1);
                8'h33: o_key = kp(3'd7, 3'd0);
                // Emulated keys without an extended prefix
                8'h76: begin o_ex_hit = 1'b1; o_ex_idx = EX_ESC;  end
                8'h66: begin o_ex_hit = 1'b1; o_ex_idx = EX_BKSP; end
                default: ;
            endcase
        end else begin
            case (i_code)
                // Right CTRL behaves as the one matrix CTRL
                8'h14: o_key = kp(CTRL_ROW, CTRL_COL);
                // Cursor keys become CTRL+M / , / . / SPACE
                8'h6B: begin o_ex_hit = 1'b1; o_ex_idx = EX_LEFT;  end
                8'h74: begin o_ex_hit = 1'b1; o_ex_idx = EX_RIGHT; end
                8'h75: begin o_ex_hit = 1'b1; o_ex_idx = EX_UP;    end
                8'h72: begin o_ex_hit = 1'b1; o_ex_idx = EX_DOWN;  end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/laser310_kbd_matrix.sv
// LASER310/VZ300 keyboard responder: decodes PS/2 set-2 bytes into a virtual
// 8x6 key matrix and answers the CPU row scan with a registered, active-low
// column word.
module laser310_kbd_matrix
    import laser310_kbd_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 6
) (
    input  logic            BASE_CLK,
    input  logic            RESET_N,
    input  logic            SC_VALID,
    input  logic [7:0]      SC_DATA,
    input  logic [ROWS-1:0] SCAN_A,
    output logic [COLS-1:0] KD,
    output logic            KEY_ANY
);

    kbd_state_t                      r_state;
    kbd_state_t                      w_state_next;
    kbd_act_t                        w_act;

    key_pos_t                        w_key;
    logic                            w_ex_hit;
    logic [2:0]                      w_ex_idx;
    logic                            w_ext_table;
    logic                            w_mapped;
    logic                            w_reset_code;

    // Physically held keys and emulated CTRL+key keys are kept apart so that
    // releasing an emulated key can never drop a real CTRL or target key.
    logic [ROWS-1:0][COLS-1:0]       r_phys;
    logic [EX_W-1:0]                 r_ex;
    logic [ROWS-1:0][COLS-1:0]       w_eff;
    key_pos_t                        w_tgt;

    logic [COLS-1:0]                 w_kd_next;
    logic [COLS-1:0]                 r_kd;

    // Extended table applies to the byte that follows an E0 (with or without F0).
    assign w_ext_table  = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
    assign w_mapped     = w_key.hit || w_ex_hit;
    assign w_reset_code = is_reset_code(SC_DATA);

    laser310_kbd_map u_map (
        .i_code   (SC_DATA),
        .i_ext    (w_ext_table),
        .o_key    (w_key),
        .o_ex_hit (w_ex_hit),
        .o_ex_idx (w_ex_idx)
    );

    // Decoder state register.
    always_ff @(posedge BASE_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Decoder next state and matrix action; only a strobed byte moves it.
    always_comb begin
        w_state_next = r_state;
        w_act        = ACT_NONE;
        if (SC_VALID) begin
            if (w_reset_code) begin
                w_state_next = ST_IDLE;
                w_act        = ACT_CLEAR;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (SC_DATA == SC_E0) begin
                            w_state_next = ST_EXT;
                        end else if (SC_DATA == SC_F0) begin
                            w_state_next = ST_BRK;
                        end else if (w_mapped) begin
                            w_act = ACT_PRESS;
                        end
                    end
                    ST_EXT: begin
                        // A repeated E0 is swallowed, the prefix still stands.
                        if (SC_DATA == SC_E0) begin
                            w_state_next = ST_EXT;
                        end else if (SC_DATA == SC_F0) begin
                            w_state_next = ST_EXT_BRK;
                        end else begin
                            w_state_next = ST_IDLE;
                            if (w_mapped) begin
                                w_act = ACT_PRESS;
                            end
                        end
                    end
                    ST_BRK, ST_EXT_BRK: begin
                        // A repeated F0 is swallowed, the break still stands.
                        if (SC_DATA != SC_F0) begin
                            w_state_next = ST_IDLE;
                            if (w_mapped) begin
                                w_act = ACT_RELEASE;
                            end
                        end
                    end
                    default: w_state_next = ST_IDLE;
                endcase
            end
        end
    end

    // Physical and emulated key registers; press/release are idempotent.
    always_ff @(posedge BASE_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_phys <= '0;
            r_ex   <= '0;
        end else begin
            case (w_act)
                ACT_CLEAR: begin
                    r_phys <= '0;
                    r_ex   <= '0;
                end
                ACT_PRESS: begin
                    if (w_key.hit) r_phys[w_key.row][w_key.col] <= 1'b1;
                    if (w_ex_hit)  r_ex[w_ex_idx]               <= 1'b1;
                end
                ACT_RELEASE: begin
                    if (w_key.hit) r_phys[w_key.row][w_key.col] <= 1'b0;
                    if (w_ex_hit)  r_ex[w_ex_idx]               <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Effective matrix: physical keys plus emulated targets, plus CTRL when
    // any emulated key is held.
    always_comb begin
        w_eff = r_phys;
        w_tgt = '0;
        for (int e = 0; e < EX_W; e++) begin
            if (r_ex[e]) begin
                w_tgt = ex_target(3'(e));
                w_eff[w_tgt.row][w_tgt.col] = 1'b1;
            end
        end
        if (|r_ex) begin
            w_eff[CTRL_ROW][CTRL_COL] = 1'b1;
        end
    end

    // Column reduction: a column reads low if any selected row has it down.
    always_comb begin
        w_kd_next = '1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (!SCAN_A[3'(r)] && w_eff[3'(r)][3'(c)]) begin
                    w_kd_next[3'(c)] = 1'b0;
                end
            end
        end
    end

    // Registered column word; a read in the same cycle as a scan byte sees
    // the matrix as it was before that byte.
    always_ff @(posedge BASE_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_kd <= '1;
        end else begin
            r_kd <= w_kd_next;
        end
    end

    assign KD      = r_kd;
    assign KEY_ANY = (|r_phys) || (|r_ex);

endmodule

// File: tb/tb_laser310_kbd_matrix.sv
// Self-checking bench for laser310_kbd_matrix: directed scenarios followed by
// random scan-code traffic, checked against a key-table model of the keyboard.
module tb_laser310_kbd_matrix;

    logic       BASE_CLK = 1'b0;
    logic       RESET_N;
    logic       SC_VALID;
    logic [7:0] SC_DATA;
    logic [7:0] SCAN_A;
    logic [5:0] KD;
    logic       KEY_ANY;

    always #10 BASE_CLK = ~BASE_CLK;

    laser310_kbd_matrix dut (
        .BASE_CLK (BASE_CLK),
        .RESET_N  (RESET_N),
        .SC_VALID (SC_VALID),
        .SC_DATA  (SC_DATA),
        .SCAN_A   (SCAN_A),
        .KD       (KD),
        .KEY_ANY  (KEY_ANY)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Key layout written as the machine's matrix: per row, KD5 down to KD0.
    logic [7:0] row_codes [8][6] = '{
        '{8'h2D, 8'h15, 8'h24, 8'h00, 8'h1D, 8'h2C},
        '{8'h2B, 8'h1C, 8'h23, 8'h14, 8'h1B, 8'h34},
        '{8'h2A, 8'h1A, 8'h21, 8'h12, 8'h22, 8'h32},
        '{8'h25, 8'h16, 8'h26, 8'h00, 8'h1E, 8'h2E},
        '{8'h3A, 8'h29, 8'h41, 8'h00, 8'h49, 8'h31},
        '{8'h3D, 8'h45, 8'h3E, 8'h4E, 8'h46, 8'h36},
        '{8'h3C, 8'h4D, 8'h43, 8'h5A, 8'h44, 8'h35},
        '{8'h3B, 8'h4C, 8'h42, 8'h52, 8'h4B, 8'h33}
    };
    // Emulated CTRL+key entries: prefix, code, target row and column.
    bit         ex_isext [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] ex_code  [6] = '{8'h6B, 8'h74, 8'h75, 8'h72, 8'h76, 8'h66};
    int         ex_row   [6] = '{4, 4, 4, 4, 5, 4};
    int         ex_col   [6] = '{5, 3, 1, 4, 2, 5};

    bit m_phys [8][6];
    bit m_ex   [6];
    bit m_pref_e0;
    bit m_pref_f0;

    task automatic m_clear();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 6; c++)
                m_phys[r][c] = 1'b0;
        for (int i = 0; i < 6; i++) m_ex[i] = 1'b0;
        m_pref_e0 = 1'b0;
        m_pref_f0 = 1'b0;
    endtask

    task automatic m_apply(input bit make, input bit ext, input logic [7:0] b);
        if (!ext) begin
            for (int r = 0; r < 8; r++)
                for (int p = 0; p < 6; p++)
                    if (row_codes[r][p] == b && b != 8'h00) m_phys[r][5-p] = make;
            if (b == 8'h59) m_phys[2][2] = make;
        end else if (b == 8'h14) begin
            m_phys[1][2] = make;
        end
        for (int i = 0; i < 6; i++)
            if (ex_isext[i] == ext && ex_code[i] == b) m_ex[i] = make;
    endtask

    task automatic m_byte(input logic [7:0] b);
        if (b == 8'hAA || b == 8'hFC || b == 8'h00 || b == 8'hFF) begin
            m_clear();
        end else if (m_pref_f0) begin
            if (b != 8'hF0) begin
                m_apply(1'b0, m_pref_e0, b);
                m_pref_e0 = 1'b0;
                m_pref_f0 = 1'b0;
            end
        end else if (m_pref_e0) begin
            if (b == 8'hF0) begin
                m_pref_f0 = 1'b1;
            end else if (b != 8'hE0) begin
                m_apply(1'b1, 1'b1, b);
                m_pref_e0 = 1'b0;
            end
        end else begin
            if (b == 8'hE0)      m_pref_e0 = 1'b1;
            else if (b == 8'hF0) m_pref_f0 = 1'b1;
            else                 m_apply(1'b1, 1'b0, b);
        end
    endtask

    function automatic logic [5:0] m_kd(input logic [7:0] a);
        bit         eff [8][6];
        bit         any_ex;
        logic [5:0] kd;
        any_ex = 1'b0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 6; c++)
                eff[r][c] = m_phys[r][c];
        for (int i = 0; i < 6; i++)
            if (m_ex[i]) begin
                eff[ex_row[i]][ex_col[i]] = 1'b1;
                any_ex = 1'b1;
            end
        if (any_ex) eff[1][2] = 1'b1;
        kd = 6'h3F;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 6; c++)
                if (!a[3'(r)] && eff[r][c]) kd[3'(c)] = 1'b0;
        return kd;
    endfunction

    function automatic logic m_any();
        logic any_down;
        any_down = 1'b0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 6; c++)
                if (m_phys[r][c]) any_down = 1'b1;
        for (int i = 0; i < 6; i++)
            if (m_ex[i]) any_down = 1'b1;
        return any_down;
    endfunction

    // ---------------- drivers ----------------
    task automatic send(input logic [7:0] b);
        @(negedge BASE_CLK);
        SC_DATA  = b;
        SC_VALID = 1'b1;
        @(negedge BASE_CLK);
        SC_VALID = 1'b0;
        m_byte(b);
    endtask

    task automatic scan_model(input string tag, input logic [7:0] a);
        @(negedge BASE_CLK);
        SCAN_A = a;
        @(negedge BASE_CLK);
        check_eq(tag, {26'd0, KD}, {26'd0, m_kd(a)});
        check_eq({tag, "_any"}, {31'd0, KEY_ANY}, {31'd0, m_any()});
    endtask

    task automatic scan_const(input string tag, input logic [7:0] a, input logic [5:0] exp);
        @(negedge BASE_CLK);
        SCAN_A = a;
        @(negedge BASE_CLK);
        check_eq(tag, {26'd0, KD}, {26'd0, exp});
    endtask

    task automatic pulse_reset();
        @(negedge BASE_CLK);
        #3;
        RESET_N = 1'b0;
        #5;
        m_clear();
        check_eq("rst_async_kd", {26'd0, KD}, 32'h3F);
        check_eq("rst_async_any", {31'd0, KEY_ANY}, 32'd0);
        @(negedge BASE_CLK);
        RESET_N = 1'b1;
    endtask

    function automatic logic [7:0] rand_normal_code();
        logic [7:0] b;
        b = 8'h00;
        while (b == 8'h00) b = row_codes[$urandom_range(0, 7)][$urandom_range(0, 5)];
        return b;
    endfunction

    function automatic logic [7:0] rand_ext_code();
        logic [7:0] t [5] = '{8'h14, 8'h6B, 8'h74, 8'h75, 8'h72};
        return t[$urandom_range(0, 4)];
    endfunction

    function automatic logic [7:0] rand_scan();
        if ($urandom_range(0, 1) == 0) return 8'($urandom);
        return ~(8'h01 << $urandom_range(0, 7));
    endfunction

    // Watchdog: the run is bounded in time regardless of DUT behaviour.
    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int         pick;

        RESET_N  = 1'b0;
        SC_VALID = 1'b0;
        SC_DATA  = 8'h00;
        SCAN_A   = 8'hFE;
        m_clear();
        repeat (3) @(negedge BASE_CLK);
        check_eq("reset_kd", {26'd0, KD}, 32'h3F);
        check_eq("reset_any", {31'd0, KEY_ANY}, 32'd0);
        RESET_N = 1'b1;
        scan_const("t1_idle_kd", 8'hFE, 6'h3F);
        check_eq("t1_idle_any", {31'd0, KEY_ANY}, 32'd0);

        // Single key press/release and row selection
        send(8'h15);
        scan_const("t2_q_row0", 8'hFE, 6'h2F);
        check_eq("t2_any", {31'd0, KEY_ANY}, 32'd1);
        scan_const("t2_q_row1", 8'hFD, 6'h3F);
        send(8'hF0); send(8'h15);
        scan_const("t2_q_rel", 8'hFE, 6'h3F);

        // Physical CTRL plus emulated left arrow
        send(8'h14);
        send(8'hE0); send(8'h6B);
        scan_const("t3_ctrl_row1", 8'hFD, 6'h3B);
        scan_const("t3_m_row4", 8'hEF, 6'h1F);
        send(8'hE0); send(8'hF0); send(8'h6B);
        scan_const("t3_ctrl_kept", 8'hFD, 6'h3B);
        scan_const("t3_m_gone", 8'hEF, 6'h3F);
        send(8'hF0); send(8'h14);
        scan_model("t3_ctrl_rel", 8'hFD);

        // Several rows selected together
        send(8'h16); send(8'h3A);
        scan_model("t4_rows34", 8'hE7);
        scan_model("t4_all_rows", 8'h00);
        scan_const("t4_no_rows", 8'hFF, 6'h3F);
        send(8'hAA);

        // Reset in the middle of a break sequence leaves nothing pending
        send(8'hF0);
        pulse_reset();
        send(8'h15);
        scan_const("t5_q_after_rst", 8'hFE, 6'h2F);
        send(8'h1D); send(8'h3A);
        send(8'hAA);
        scan_const("t5_aa_clear", 8'h00, 6'h3F);
        check_eq("t5_aa_any", {31'd0, KEY_ANY}, 32'd0);

        // Typematic repeats, then one break; stray extended byte
        send(8'h1D); send(8'h1D); send(8'h1D);
        scan_const("t6_w_held", 8'hFE, 6'h3D);
        send(8'hF0); send(8'h1D);
        scan_const("t6_w_rel", 8'hFE, 6'h3F);
        send(8'hE0); send(8'h99);
        send(8'h15);
        scan_const("t6_idle_after_e0", 8'hFE, 6'h2F);
        send(8'hAA);

        // Release of a key that is not down
        send(8'h24);
        send(8'hF0); send(8'h2D);
        scan_model("t7_stray_break", 8'hFE);
        send(8'hAA);

        // Scan byte and CPU read in the same cycle
        @(negedge BASE_CLK);
        SCAN_A = 8'hFE;
        @(negedge BASE_CLK);
        SC_DATA  = 8'h15;
        SC_VALID = 1'b1;
        @(negedge BASE_CLK);
        SC_VALID = 1'b0;
        check_eq("t8_same_cycle_old", {26'd0, KD}, 32'h3F);
        m_byte(8'h15);
        @(negedge BASE_CLK);
        check_eq("t8_next_cycle_new", {26'd0, KD}, 32'h2F);
        send(8'hAA);

        // Random traffic
        for (int it = 0; it < 400; it++) begin
            pick = $urandom_range(0, 99);
            if (pick < 45) begin
                send(rand_normal_code());
            end else if (pick < 53) begin
                b = ($urandom_range(0, 2) == 0) ? 8'h76 :
                    ($urandom_range(0, 1) == 0) ? 8'h66 : 8'h59;
                send(b);
            end else if (pick < 65) begin
                send(8'hE0); send(rand_ext_code());
            end else if (pick < 82) begin
                send(8'hF0); send(rand_normal_code());
            end else if (pick < 90) begin
                send(8'hE0); send(8'hF0); send(rand_ext_code());
            end else if (pick < 94) begin
                send(($urandom_range(0, 1) == 0) ? 8'hE0 : 8'hF0);
            end else if (pick < 98) begin
                send(8'($urandom));
            end else begin
                send(8'hAA);
            end
            if ($urandom_range(0, 1) == 0) scan_model("rand_scan", rand_scan());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
